ntt_iter_core: RTL and testbench
================================

Name: ntt_iter_core

Overview:
- Parametrised, sequential successor to the fixed 4-point combinational NTT.
- Computes an N-point forward NTT or inverse NTT (INTT) over Z_Q on a packed coefficient vector.
- Uses one shared radix-2 butterfly, iterated over log2(N) stages, with valid/ready handshakes on both ends.
- Sits between the polynomial coefficient buffer and the pointwise-multiply stage.

Parameters:
- N, 4: transform length; power of two, N ≥ 2.
- W, 9: coefficient width in bits; Q > 2^(W-1) and Q < 2^W + 1 are required.
- Q, 257: prime modulus.
- OMEGA, 16: primitive N-th root of unity mod Q.
- OMEGA_INV, 241: OMEGA^-1 mod Q.
- N_INV, 193: N^-1 mod Q.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input vector valid
- in_ready  out  1  core can accept a vector
- in_inv  in  1  sampled with the input: 0 = NTT, 1 = INTT
- in_data  in  N*W  coefficients; coefficient j in bits [j*W +: W]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  N*W  result; coefficient k in bits [k*W +: W]

Behaviour:
- Reset, asynchronous: state=IDLE, in_ready=1, out_valid=0, out_data=0, all internal coefficient registers and counters cleared.
- States and transitions:
  - IDLE → COMPUTE on in_valid && in_ready.
  - COMPUTE → DONE (NTT) or SCALE (INTT) after the last butterfly.
  - SCALE → DONE after N cycles.
  - DONE → IDLE on out_ready.
- in_ready = (state==IDLE). in_valid in any other state is ignored; there is no queueing.
- Load cycle:
  - Each coefficient is stored at its bit-reversed index (log2(N) bits).
  - Values ≥ Q are reduced by one conditional subtract of Q.
  - in_inv is latched at the same time.
- COMPUTE: one butterfly per cycle; stage s = 0..log2(N)-1, m = 2^(s+1), group base b, offset j < m/2.
  - Operands: u = X[b+j], v = X[b+j+m/2], w = R^(j*N/m), where R = OMEGA, or OMEGA_INV when inv.
  - Writes: X[b+j] ← (u + w*v) mod Q and X[b+j+m/2] ← (u − w*v) mod Q, both in the same cycle.
  - Total butterfly cycles C = (N/2)*log2(N).
  - Order: j fastest, then b, then s.
- SCALE (inverse only): one coefficient per cycle, X[k] ← X[k]*N_INV mod Q, k = 0..N-1.
- Latency: with the accept edge at cycle t, out_valid rises at t+1+C for NTT and t+1+C+N for INTT. For N=4 that is t+5 and t+9.
- out_data is the registered coefficient array. It is defined only while out_valid=1 and is held stable while out_valid && !out_ready.
- DONE with out_ready=1 and in_valid=1 in the same cycle: the vector is not accepted (in_ready=0); it is accepted in IDLE on the following cycle at the earliest.
- Reset asserted mid-COMPUTE or mid-SCALE: the operation is abandoned, nothing is emitted, and all state returns to reset values.
- Arithmetic rules:
  - All stored values are in [0, Q-1].
  - Products are 2W bits wide, reduced mod Q.
  - Add is followed by a conditional subtract of Q; subtract adds Q on borrow.
- Twiddles and bit-reverse indices are elaboration-time constants; no runtime root computation.

Decomposition:
- Package ntt_pkg holds:
  - state enum {IDLE, COMPUTE, SCALE, DONE};
  - functions clog2, bitrev(idx, bits), modpow(base, exp, Q) for the twiddle tables;
  - the modular helpers mod_add, mod_sub, mod_mul.
- One sub-module, ntt_butterfly: combinational, inputs u, v, w, outputs (u+wv) mod Q and (u−wv) mod Q.
- Counters, the FSM and the coefficient register array stay in ntt_iter_core.

Test Plan:
- NTT of [1,1,1,1] (in_data = 36'h008040201) → out [4,0,0,0]; out_valid exactly 5 cycles after the accept edge.
- NTT of [0,1,0,0] → out [1,16,256,241]; NTT of [1,0,0,0] → [1,1,1,1].
- INTT (in_inv=1) of [4,0,0,0] → [1,1,1,1]; INTT of [1,16,256,241] → [0,1,0,0]; out_valid 9 cycles after accept.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_data is unchanged, in_ready stays 0, and in_valid pulses are dropped. Then out_ready=1 → IDLE the next cycle.
- Input reduction: coefficient 258 in slot 0, others 0 → out [1,1,1,1].
- Assert rst during cycle 2 of COMPUTE → out_valid=0, in_ready=1 immediately. The next vector [1,1,1,1] yields [4,0,0,0] with normal latency.

Source files
------------

// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared types, elaboration helpers and modular arithmetic for the NTT core
package ntt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        SCALE,
        DONE
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int bitrev(input int idx, input int bits);
        int r;
        r = 0;
        for (int i = 0; i < bits; i++) begin
            r = (r << 1) | ((idx >> i) & 1);
        end
        return r;
    endfunction

    function automatic longint modpow(input longint base, input int e, input longint q);
        longint r;
        r = 1;
        for (int i = 0; i < e; i++) begin
            r = (r * base) % q;
        end
        return r;
    endfunction

    // Operands are assumed already in [0, q-1]
    function automatic logic [63:0] mod_add(input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] q);
        logic [63:0] s;
        s = a + b;
        return (s >= q) ? s - q : s;
    endfunction

    function automatic logic [63:0] mod_sub(input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] q);
        return (a >= b) ? a - b : a + q - b;
    endfunction

    function automatic logic [63:0] mod_mul(input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] q);
        return (a * b) % q;
    endfunction

endpackage

// File: rtl/ntt_butterfly.sv
// rtl/ntt_butterfly.sv - combinational Cooley-Tukey radix-2 butterfly over Z_Q
module ntt_butterfly
    import ntt_pkg::*;
#(
    parameter int W = 9,
    parameter int Q = 257
) (
    input  logic [W-1:0] u,
    input  logic [W-1:0] v,
    input  logic [W-1:0] w,
    output logic [W-1:0] sum,
    output logic [W-1:0] dif
);

    logic [63:0] t;

    // Twiddle product shared by both outputs
    always_comb begin
        t   = mod_mul(64'(v), 64'(w), 64'(Q));
        sum = W'(mod_add(64'(u), t, 64'(Q)));
        dif = W'(mod_sub(64'(u), t, 64'(Q)));
    end

endmodule

// File: rtl/ntt_iter_core.sv
// rtl/ntt_iter_core.sv - iterative N-point NTT/INTT using one shared butterfly
module ntt_iter_core
    import ntt_pkg::*;
#(
    parameter int N         = 4,
    parameter int W         = 9,
    parameter int Q         = 257,
    parameter int OMEGA     = 16,
    parameter int OMEGA_INV = 241,
    parameter int N_INV     = 193
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_inv,
    input  logic [N*W-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] out_data
);

    localparam int LOGN = clog2(N);
    // One extra bit so a span of N is representable
    localparam int CW = LOGN + 1;
    localparam logic [W-1:0] QV = W'(Q);

    state_t        state;
    logic          inv;
    logic [W-1:0]  x      [N];
    logic [W-1:0]  ld     [N];
    logic [W-1:0]  tw_fwd [N];
    logic [W-1:0]  tw_inv [N];

    logic [CW-1:0] stg, grp, off, scl;
    logic [CW-1:0] half, span;
    logic [LOGN-1:0] ia, ib, ti, si;
    logic [W-1:0]  bf_w, bf_sum, bf_dif, scaled;

    // Twiddle tables, bit-reversed reduced load image and output packing
    for (genvar k = 0; k < N; k++) begin : g_lane
        localparam logic [LOGN-1:0] BR = LOGN'(bitrev(k, LOGN));
        logic [W-1:0] raw;
        assign tw_fwd[k] = W'(modpow(longint'(OMEGA), k, longint'(Q)));
        assign tw_inv[k] = W'(modpow(longint'(OMEGA_INV), k, longint'(Q)));
        assign raw       = in_data[k*W +: W];
        assign ld[BR]    = ({1'b0, raw} >= (W+1)'(Q)) ? raw - QV : raw;
        assign out_data[k*W +: W] = x[k];
    end

    // Operand addressing for the current butterfly and scale step
    always_comb begin
        half   = CW'(1) << stg;
        span   = half << 1;
        ia     = LOGN'(grp + off);
        ib     = LOGN'(grp + off + half);
        ti     = LOGN'(off << (CW'(LOGN - 1) - stg));
        bf_w   = inv ? tw_inv[ti] : tw_fwd[ti];
        si     = LOGN'(scl);
        scaled = W'(mod_mul(64'(x[si]), 64'(N_INV), 64'(Q)));
    end

    ntt_butterfly #(
        .W (W),
        .Q (Q)
    ) u_bfly (
        .u   (x[ia]),
        .v   (x[ib]),
        .w   (bf_w),
        .sum (bf_sum),
        .dif (bf_dif)
    );

    // Control FSM, loop counters and coefficient storage; out_valid is
    // registered from DONE, so it trails the final coefficient write by a cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            inv       <= 1'b0;
            stg       <= '0;
            grp       <= '0;
            off       <= '0;
            scl       <= '0;
            x         <= '{default: '0};
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x        <= ld;
                        inv      <= in_inv;
                        stg      <= '0;
                        grp      <= '0;
                        off      <= '0;
                        in_ready <= 1'b0;
                        state    <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    x[ia] <= bf_sum;
                    x[ib] <= bf_dif;
                    if (off == half - CW'(1)) begin
                        off <= '0;
                        if (grp + span == CW'(N)) begin
                            grp <= '0;
                            if (stg == CW'(LOGN - 1)) begin
                                stg   <= '0;
                                scl   <= '0;
                                state <= inv ? SCALE : DONE;
                            end else begin
                                stg <= stg + CW'(1);
                            end
                        end else begin
                            grp <= grp + span;
                        end
                    end else begin
                        off <= off + CW'(1);
                    end
                end
                SCALE: begin
                    x[si] <= scaled;
                    scl   <= scl + CW'(1);
                    if (scl == CW'(N - 1)) state <= DONE;
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_iter_core.sv
// tb/tb_ntt_iter_core.sv - scoreboard bench for ntt_iter_core with directed vectors
module tb_ntt_iter_core;

    localparam int N = 4;
    localparam int W = 9;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic           in_inv;
    logic [N*W-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [N*W-1:0] out_data;

    typedef struct {
        logic [N*W-1:0] data;
        int             lat;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   seen = 0;
    int   expected_total = 0;
    time  acc_time = 0;
    logic prev_ov = 1'b0;

    always #5 clk = ~clk;

    ntt_iter_core #(
        .N(N), .W(W), .Q(257), .OMEGA(16), .OMEGA_INV(241), .N_INV(193)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inv    (in_inv),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    function automatic logic [N*W-1:0] pack(input int c0, input int c1, input int c2, input int c3);
        return {W'(c3), W'(c2), W'(c1), W'(c0)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N*W-1:0] d, input logic iv, input logic [N*W-1:0] e);
        bit ok;
        ok = 1'b0;
        tick();
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = iv;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (in_ready) begin
                @(posedge clk);
                acc_time = $time;
                sbq.push_back('{e, iv ? 9 : 5});
                expected_total++;
                ok = 1'b1;
                #1;
            end else begin
                tick();
            end
        end
        in_valid = 1'b0;
        chk("accept", 64'(ok), 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sbq.size() != 0; i++) tick();
        chk("drain", 64'(sbq.size()), 64'd0);
    endtask

    // Monitor: compares every presented result against the scoreboard head
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sbq.size() == 0) begin
                chk("spurious_out", 64'd1, 64'd0);
            end else begin
                if (!prev_ov)
                    chk("latency", 64'(($time - 5 - acc_time) / 10), 64'(sbq[0].lat));
                chk("out_data", 64'(out_data), 64'(sbq[0].data));
                if (out_ready) begin
                    void'(sbq.pop_front());
                    seen++;
                end
            end
        end
        prev_ov = out_valid;
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_inv    = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) tick();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        rst = 1'b0;

        // Forward transforms
        send(36'h008040201, 1'b0, pack(4, 0, 0, 0));
        drain();
        send(pack(0, 1, 0, 0), 1'b0, pack(1, 16, 256, 241));
        send(pack(1, 0, 0, 0), 1'b0, pack(1, 1, 1, 1));
        drain();

        // Inverse transforms
        send(pack(4, 0, 0, 0), 1'b1, pack(1, 1, 1, 1));
        send(pack(1, 16, 256, 241), 1'b1, pack(0, 1, 0, 0));
        drain();

        // Input reduction of a value above Q
        send(pack(258, 0, 0, 0), 1'b0, pack(1, 1, 1, 1));
        drain();

        // Backpressure in DONE with in_valid pulses that must be dropped
        out_ready = 1'b0;
        send(pack(0, 1, 0, 0), 1'b0, pack(1, 16, 256, 241));
        for (int i = 0; i < 50 && !out_valid; i++) tick();
        chk("bp_valid", 64'(out_valid), 64'd1);
        in_data = pack(7, 7, 7, 7);
        for (int i = 0; i < 10; i++) begin
            tick();
            in_valid = ~in_valid;
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        tick();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bp_idle_ready", 64'(in_ready), 64'd1);
        chk("bp_idle_valid", 64'(out_valid), 64'd0);
        drain();

        // Reset during the second COMPUTE cycle abandons the vector
        send(36'h008040201, 1'b0, pack(4, 0, 0, 0));
        tick();
        rst = 1'b1;
        void'(sbq.pop_back());
        expected_total--;
        #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        tick();
        rst = 1'b0;
        send(36'h008040201, 1'b0, pack(4, 0, 0, 0));
        drain();

        repeat (5) tick();
        chk("emitted", 64'(seen), 64'(expected_total));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
